// File: rtl/branch_predict_unit_pkg.sv
// branch_predict_unit_pkg: RV32I control-transfer encodings and BTB counter states.
package branch_predict_unit_pkg;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] F3_BEQ    = 3'b000;
  localparam logic [2:0] F3_BNE    = 3'b001;
  localparam logic [2:0] F3_BLT    = 3'b100;
  localparam logic [2:0] F3_BGE    = 3'b101;
  localparam logic [2:0] F3_BLTU   = 3'b110;
  localparam logic [2:0] F3_BGEU   = 3'b111;
  localparam logic [1:0] FWD_WB_ALU     = 2'b01;
  localparam logic [1:0] FWD_WB_ALU_MEM = 2'b10;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;
  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    return taken ? ((c == ST) ? ST : ctr_e'(c + 2'd1)) : ((c == SNT) ? SNT : ctr_e'(c - 2'd1));
  endfunction
endpackage

// File: rtl/branch_predict_unit_cond.sv
// branch_predict_unit_cond: evaluates an RV32I branch condition from funct3.
module branch_predict_unit_cond
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      funct3_i,
  output logic            cond_o
);
  logic eq, lt, ltu;
  always_comb begin
    eq     = rs1_i == rs2_i;
    lt     = $signed(rs1_i) < $signed(rs2_i);
    ltu    = rs1_i < rs2_i;
    cond_o = (funct3_i == F3_BEQ)  ? eq   :
             (funct3_i == F3_BNE)  ? !eq  :
             (funct3_i == F3_BLT)  ? lt   :
             (funct3_i == F3_BGE)  ? !lt  :
             (funct3_i == F3_BLTU) ? ltu  :
             (funct3_i == F3_BGEU) ? !ltu : 1'b0;
  end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: ID-stage branch resolution with a direct-mapped BTB and registered redirect.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  if_pc_i,
  output logic             if_pred_taken_o,
  output logic [XLEN-1:0]  if_pred_target_o,
  input  logic             rv_valid_i,
  input  logic [XLEN-1:0]  rv_pc_i,
  input  logic [6:0]       rv_opcode_i,
  input  logic [2:0]       rv_funct3_i,
  input  logic [XLEN-1:0]  rv_imm_i,
  input  logic [XLEN-1:0]  rv_src1_i,
  input  logic [XLEN-1:0]  rv_src2_i,
  input  logic [1:0]       fwd_sel1_i,
  input  logic [1:0]       fwd_sel2_i,
  input  logic [XLEN-1:0]  wb_alu_i,
  input  logic [XLEN-1:0]  wb_alu_mem_i,
  input  logic             rv_pred_taken_i,
  input  logic [XLEN-1:0]  rv_pred_target_i,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_addr_o,
  output logic [CNT_W-1:0] mispredict_cnt_o
);
  localparam int IDX = $clog2(BTB_DEPTH);
  localparam int TAG = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);
  logic             valid_q [BTB_DEPTH];
  logic [TAG-1:0]   tag_q   [BTB_DEPTH];
  logic [XLEN-1:0]  tgt_q   [BTB_DEPTH];
  ctr_e             ctr_q   [BTB_DEPTH];
  logic             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]  redirect_addr_q, redirect_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX-1:0]   l_idx, r_idx;
  logic [TAG-1:0]   r_tag;
  logic             l_hit, r_hit;
  logic [XLEN-1:0]  op1, op2, jalr_sum, target;
  logic             is_b, is_jal, is_jalr, ctl, cond, taken, fire, btb_we;
  ctr_e             ctr_d;
  branch_predict_unit_cond #(.XLEN(XLEN)) u_cond (
    .rs1_i   (op1),
    .rs2_i   (op2),
    .funct3_i(rv_funct3_i),
    .cond_o  (cond)
  );
  always_comb begin
    l_idx            = if_pc_i[IDX+1:2];
    l_hit            = valid_q[l_idx] && tag_q[l_idx] == if_pc_i[XLEN-1:IDX+2];
    if_pred_taken_o  = l_hit && ctr_q[l_idx][1];
    if_pred_target_o = l_hit ? tgt_q[l_idx] : if_pc_i + FOUR;
    op1 = (fwd_sel1_i == FWD_WB_ALU) ? wb_alu_i : (fwd_sel1_i == FWD_WB_ALU_MEM) ? wb_alu_mem_i : rv_src1_i;
    op2 = (fwd_sel2_i == FWD_WB_ALU) ? wb_alu_i : (fwd_sel2_i == FWD_WB_ALU_MEM) ? wb_alu_mem_i : rv_src2_i;
    is_b     = rv_opcode_i == OP_BRANCH;
    is_jal   = rv_opcode_i == OP_JAL;
    is_jalr  = rv_opcode_i == OP_JALR;
    ctl      = is_b || is_jal || is_jalr;
    taken    = is_b ? cond : (is_jal || is_jalr);
    jalr_sum = op1 + rv_imm_i;
    target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : rv_pc_i + rv_imm_i;
    fire     = rv_valid_i && ctl && ((taken != rv_pred_taken_i) || (taken && target != rv_pred_target_i));
    r_idx    = rv_pc_i[IDX+1:2];
    r_tag    = rv_pc_i[XLEN-1:IDX+2];
    r_hit    = valid_q[r_idx] && tag_q[r_idx] == r_tag;
    // Not-taken branches that miss leave the BTB alone; everything else resolved writes it.
    btb_we   = rv_valid_i && ctl && (!is_b || r_hit || taken);
    ctr_d    = !is_b ? ST : r_hit ? ctr_next(ctr_q[r_idx], taken) : WT;
    redirect_valid_d = fire;
    redirect_addr_d  = fire ? (taken ? target : rv_pc_i + FOUR) : redirect_addr_q;
    cnt_d            = (fire && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= WNT;
      end
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= '0;
      cnt_q            <= '0;
    end else begin
      if (btb_we) begin
        valid_q[r_idx] <= 1'b1;
        tag_q[r_idx]   <= r_tag;
        ctr_q[r_idx]   <= ctr_d;
        if (taken) tgt_q[r_idx] <= target;
      end
      redirect_valid_q <= redirect_valid_d;
      redirect_addr_q  <= redirect_addr_d;
      cnt_q            <= cnt_d;
    end
  end
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_addr_o  = redirect_addr_q;
  assign mispredict_cnt_o = cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed vectors with a scoreboard queue checked by a redirect monitor.
module tb_branch_predict_unit;
  localparam logic [6:0] B = 7'h63, JAL = 7'h6F, JALR = 7'h67, OPR = 7'h33;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        rv_valid;
  logic [31:0] rv_pc, rv_imm, rv_src1, rv_src2, wb_alu, wb_alu_mem, rv_pred_target;
  logic [6:0]  rv_opcode;
  logic [2:0]  rv_funct3;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic        rv_pred_taken;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic [2:0]  mispredict_cnt;
  typedef struct {logic fire; logic [31:0] addr; logic [2:0] cnt;} exp_t;
  exp_t        q[$];
  int          checks = 0, errors = 0;
  logic [2:0]  exp_cnt = 3'd0;

  always #5 clk = ~clk;

  branch_predict_unit #(.XLEN(32), .BTB_DEPTH(16), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_pc_i(if_pc), .if_pred_taken_o(if_pred_taken), .if_pred_target_o(if_pred_target),
    .rv_valid_i(rv_valid), .rv_pc_i(rv_pc), .rv_opcode_i(rv_opcode), .rv_funct3_i(rv_funct3),
    .rv_imm_i(rv_imm), .rv_src1_i(rv_src1), .rv_src2_i(rv_src2),
    .fwd_sel1_i(fwd_sel1), .fwd_sel2_i(fwd_sel2), .wb_alu_i(wb_alu), .wb_alu_mem_i(wb_alu_mem),
    .rv_pred_taken_i(rv_pred_taken), .rv_pred_target_i(rv_pred_target),
    .redirect_valid_o(redirect_valid), .redirect_addr_o(redirect_addr),
    .mispredict_cnt_o(mispredict_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.fire});
        chk("mispredict_cnt", {29'd0, mispredict_cnt}, {29'd0, e.cnt});
        if (e.fire) chk("redirect_addr", redirect_addr, e.addr);
      end else begin
        chk("idle_redirect", {31'd0, redirect_valid}, 32'd0);
      end
    end
  end

  task automatic resolve(input logic vld, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] s1, input logic [31:0] s2,
                         input logic [1:0] fs1, input logic [1:0] fs2,
                         input logic ptk, input logic [31:0] ptgt,
                         input logic efire, input logic [31:0] eaddr);
    rv_valid = vld; rv_opcode = op; rv_funct3 = f3; rv_pc = pc; rv_imm = imm;
    rv_src1 = s1; rv_src2 = s2; fwd_sel1 = fs1; fwd_sel2 = fs2;
    rv_pred_taken = ptk; rv_pred_target = ptgt;
    @(posedge clk);
    if (efire && exp_cnt != 3'd7) exp_cnt++;
    q.push_back('{efire, eaddr, exp_cnt});
    @(negedge clk);
    rv_valid = 1'b0; fwd_sel1 = 2'b00; fwd_sel2 = 2'b00;
  endtask

  task automatic look(input logic [31:0] pc, input logic et, input logic [31:0] etgt);
    if_pc = pc;
    #1;
    chk("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, et});
    chk("if_pred_target", if_pred_target, etgt);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; if_pc = 32'h100; rv_valid = 1'b0; rv_pc = '0; rv_opcode = '0; rv_funct3 = '0;
    rv_imm = '0; rv_src1 = '0; rv_src2 = '0; fwd_sel1 = '0; fwd_sel2 = '0; wb_alu = '0;
    wb_alu_mem = '0; rv_pred_taken = 1'b0; rv_pred_target = '0;
    repeat (2) @(negedge clk);
    chk("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("reset_redirect_addr", redirect_addr, 32'd0);
    chk("reset_cnt", {29'd0, mispredict_cnt}, 32'd0);
    look(32'h100, 1'b0, 32'h104);
    rst_n = 1'b1;
    @(negedge clk);
    resolve(1, B, 3'd0, 32'h100, 32'h40, 32'd5, 32'd5, 2'd0, 2'd0, 0, 32'h104, 1, 32'h140);
    look(32'h100, 1'b1, 32'h140);
    resolve(1, B, 3'd0, 32'h100, 32'h40, 32'd5, 32'd6, 2'd0, 2'd0, 1, 32'h140, 1, 32'h104);
    look(32'h100, 1'b0, 32'h140);
    for (int i = 0; i < 3; i++) begin
      resolve(1, B, 3'd0, 32'h100, 32'h40, 32'd5, 32'd6, 2'd0, 2'd0, 0, 32'h104, 0, 32'h0);
      look(32'h100, 1'b0, 32'h140);
    end
    resolve(1, B, 3'd0, 32'h100, 32'h40, 32'd7, 32'd7, 2'd0, 2'd0, 0, 32'h140, 1, 32'h140);
    look(32'h100, 1'b0, 32'h140);
    resolve(1, B, 3'd0, 32'h100, 32'h40, 32'd7, 32'd7, 2'd0, 2'd0, 0, 32'h140, 1, 32'h140);
    look(32'h100, 1'b1, 32'h140);
    resolve(1, B, 3'd4, 32'h200, 32'h20, 32'hFFFF_FFFF, 32'd1, 2'd0, 2'd0, 0, 32'h204, 1, 32'h220);
    look(32'h200, 1'b1, 32'h220);
    look(32'h100, 1'b0, 32'h104);
    resolve(1, B, 3'd6, 32'h30C, 32'h20, 32'hFFFF_FFFF, 32'd1, 2'd0, 2'd0, 0, 32'h310, 0, 32'h0);
    look(32'h30C, 1'b0, 32'h310);
    wb_alu_mem = 32'd4;
    resolve(1, B, 3'd1, 32'h400, 32'h10, 32'd3, 32'd3, 2'd0, 2'd2, 1, 32'h410, 0, 32'h0);
    resolve(1, B, 3'd2, 32'h500, 32'h10, 32'd1, 32'd2, 2'd0, 2'd0, 0, 32'h504, 0, 32'h0);
    look(32'h500, 1'b0, 32'h504);
    resolve(0, JAL, 3'd0, 32'h600, 32'h8, 32'd0, 32'd0, 2'd0, 2'd0, 0, 32'h604, 0, 32'h0);
    look(32'h600, 1'b0, 32'h604);
    resolve(1, OPR, 3'd0, 32'h610, 32'h8, 32'd5, 32'd5, 2'd0, 2'd0, 1, 32'h618, 0, 32'h0);
    resolve(1, JAL, 3'd0, 32'h600, 32'hFFFF_FFF8, 32'd0, 32'd0, 2'd0, 2'd0, 0, 32'h604, 1, 32'h5F8);
    look(32'h600, 1'b1, 32'h5F8);
    wb_alu = 32'h2001;
    resolve(1, JALR, 3'd0, 32'h700, 32'd2, 32'h9999, 32'd0, 2'd1, 2'd0, 1, 32'h2000, 1, 32'h2002);
    look(32'h700, 1'b1, 32'h2002);
    wb_alu_mem = 32'h3000;
    resolve(1, JALR, 3'd0, 32'h704, 32'd4, 32'h9999, 32'd0, 2'd2, 2'd0, 1, 32'h3004, 0, 32'h0);
    resolve(1, JALR, 3'd0, 32'h708, 32'd0, 32'h4000, 32'd0, 2'd3, 2'd0, 1, 32'h4000, 0, 32'h0);
    resolve(1, JAL, 3'd0, 32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0, 2'd0, 2'd0, 0, 32'hFFFF_FFF4, 1, 32'h10);
    resolve(1, B, 3'd5, 32'h800, 32'h8, 32'd1, 32'hFFFF_FFFF, 2'd0, 2'd0, 0, 32'h804, 1, 32'h808);
    resolve(1, B, 3'd7, 32'h810, 32'h8, 32'd1, 32'hFFFF_FFFF, 2'd0, 2'd0, 0, 32'h814, 0, 32'h0);
    resolve(1, JAL, 3'd0, 32'h900, 32'hFFFF_FFF8, 32'd0, 32'd0, 2'd0, 2'd0, 0, 32'h904, 1, 32'h8F8);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_clears_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("rst_clears_cnt", {29'd0, mispredict_cnt}, 32'd0);
    exp_cnt = 3'd0;
    look(32'h600, 1'b0, 32'h604);
    look(32'h200, 1'b0, 32'h204);
    @(negedge clk);
    chk("rst_held_redirect", {31'd0, redirect_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    resolve(1, B, 3'd0, 32'h100, 32'h40, 32'd9, 32'd9, 2'd0, 2'd0, 0, 32'h104, 1, 32'h140);
    look(32'h100, 1'b1, 32'h140);
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
